// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types and default widths for the frame buffer arbiter
package serdes_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_READ_WAIT,
      ST_READ_DONE
   } state_t;

   typedef enum logic {
      GRANT_DES = 1'b0,
      GRANT_SER = 1'b1
   } grant_t;

endpackage

// File: rtl/serdes_buffer_arbiter_if.sv
// rtl/serdes_buffer_arbiter_if.sv - requester and buffer-memory signals of the arbiter
interface serdes_buffer_arbiter_if
   import serdes_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              desReq;
   logic [DATA_W-1:0] desData;
   logic              desAck;
   logic              serReq;
   logic              serAck;
   logic [DATA_W-1:0] serData;
   logic [ADDR_W-1:0] memAddr;
   logic              memWe;
   logic              memRe;
   logic [DATA_W-1:0] memWdata;
   logic [DATA_W-1:0] memRdata;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;

   modport master (
      output desReq, desData, serReq, memRdata,
      input  desAck, serAck, serData, memAddr, memWe, memRe, memWdata, full, empty, count
   );

   modport slave (
      input  desReq, desData, serReq, memRdata,
      output desAck, serAck, serData, memAddr, memWe, memRe, memWdata, full, empty, count
   );

endinterface

// File: rtl/wrap_pointer.sv
// rtl/wrap_pointer.sv - buffer pointer with clear and increment, wrapping at 2**ADDR_W
module wrap_pointer #(
   parameter int ADDR_W = 16
) (
   input  logic              i_clk,
   input  logic              i_clear,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_ptr
);

   logic [ADDR_W-1:0] r_ptr;

   always_ff @(posedge i_clk) begin
      if (i_clear)
         r_ptr <= '0;
      else if (i_inc)
         r_ptr <= r_ptr + ADDR_W'(1);
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/serdes_buffer_arbiter.sv
// rtl/serdes_buffer_arbiter.sv - round-robin sequencer for the shared deserializer/serializer frame buffer
module serdes_buffer_arbiter
   import serdes_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                  clock,
   input  logic                  reset,
   serdes_buffer_arbiter_if.slave bus
);

   localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_next;
   grant_t            r_lastGrant;
   logic [DATA_W-1:0] r_desWord;
   logic [DATA_W-1:0] r_serData;
   logic [ADDR_W-1:0] r_memAddr;
   logic [ADDR_W-1:0] w_memAddr;
   logic [ADDR_W-1:0] w_wrPtr;
   logic [ADDR_W-1:0] w_rdPtr;
   logic [ADDR_W:0]   r_count;
   logic              w_full;
   logic              w_empty;
   logic              w_desAck;
   logic              w_serAck;
   logic              w_desElig;
   logic              w_serElig;
   logic              w_wrInc;
   logic              w_rdInc;

   assign w_full    = (r_count == DEPTH_CNT);
   assign w_empty   = (r_count == '0);
   assign w_desAck  = (r_state == ST_WRITE);
   assign w_serAck  = (r_state == ST_READ_DONE);
   assign w_wrInc   = (r_state == ST_WRITE);
   assign w_rdInc   = (r_state == ST_READ_WAIT);

   // A requester still holding req during its own ack cycle must not win again.
   assign w_desElig = bus.desReq & ~w_full & ~w_desAck;
   assign w_serElig = bus.serReq & ~w_empty & ~w_serAck;

   wrap_pointer #(.ADDR_W(ADDR_W)) u_wr_ptr (
      .i_clk   (clock),
      .i_clear (reset),
      .i_inc   (w_wrInc),
      .o_ptr   (w_wrPtr)
   );

   wrap_pointer #(.ADDR_W(ADDR_W)) u_rd_ptr (
      .i_clk   (clock),
      .i_clear (reset),
      .i_inc   (w_rdInc),
      .o_ptr   (w_rdPtr)
   );

   always_ff @(posedge clock) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_desElig && w_serElig)
               w_next = (r_lastGrant == GRANT_SER) ? ST_WRITE : ST_READ;
            else if (w_desElig)
               w_next = ST_WRITE;
            else if (w_serElig)
               w_next = ST_READ;
         end
         ST_WRITE:     w_next = ST_IDLE;
         ST_READ:      w_next = ST_READ_WAIT;
         ST_READ_WAIT: w_next = ST_READ_DONE;
         ST_READ_DONE: w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   // Address is only driven during a strobe; otherwise the last one is held.
   always_comb begin
      w_memAddr = r_memAddr;
      if (r_state == ST_WRITE)
         w_memAddr = w_wrPtr;
      else if (r_state == ST_READ)
         w_memAddr = w_rdPtr;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_lastGrant <= GRANT_SER;
         r_count     <= '0;
         r_serData   <= '0;
         r_memAddr   <= '0;
         r_desWord   <= '0;
      end else begin
         r_memAddr <= w_memAddr;
         if (r_state == ST_IDLE && w_next == ST_WRITE)
            r_desWord <= bus.desData;
         if (r_state == ST_WRITE) begin
            r_count     <= r_count + CNT_ONE;
            r_lastGrant <= GRANT_DES;
         end
         if (r_state == ST_READ_WAIT) begin
            r_serData   <= bus.memRdata;
            r_count     <= r_count - CNT_ONE;
            r_lastGrant <= GRANT_SER;
         end
      end
   end

   assign bus.memWe    = (r_state == ST_WRITE);
   assign bus.memRe    = (r_state == ST_READ);
   assign bus.desAck   = w_desAck;
   assign bus.serAck   = w_serAck;
   assign bus.memAddr  = w_memAddr;
   assign bus.memWdata = r_desWord;
   assign bus.serData  = r_serData;
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.count    = r_count;

endmodule
